// File: rtl/countdown_bcd_if.sv
// Control and display bundle for countdown_bcd: master drives the control pulses and load value,
// slave (the counter) returns the BCD count and status flags.
interface countdown_bcd_if;
   logic       tick;
   logic       load;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic       start;
   logic       stop;
   logic       clear;
   logic [7:0] min_out;
   logic [7:0] sec_out;
   logic       running;
   logic       alarm;
   logic       done;
   logic       load_err;

   modport master (
      output tick, load, load_min, load_sec, start, stop, clear,
      input  min_out, sec_out, running, alarm, done, load_err
   );

   modport slave (
      input  tick, load, load_min, load_sec, start, stop, clear,
      output min_out, sec_out, running, alarm, done, load_err
   );
endinterface

// File: rtl/countdown_bcd.sv
// mm:ss BCD countdown driven by timer ticks, TICK_DIV ticks per second.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the last valid loaded value on expiry instead of alarming.
module countdown_bcd #(
   parameter int unsigned TICK_DIV = 32,
   parameter int unsigned PRESC_W  = 8
) (
   input logic            clk,
   input logic            reset,
   countdown_bcd_if.slave bus
);
   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StPause = 2'd2;
   localparam logic [1:0] StAlarm = 2'd3;

   localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(TICK_DIV - 1);

   logic [1:0]         state_q, state_d;
   logic [7:0]         min_q, min_d;
   logic [7:0]         sec_q, sec_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               done_q, done_d;
   logic               load_err_q, load_err_d;
   logic               load_valid;
   logic               count_nz;
   logic [15:0]        dec;

   // Borrow chain: seconds units, seconds tens, then minutes (seconds wrap to 59).
   function automatic logic [15:0] bcd_dec(input logic [7:0] m, input logic [7:0] s);
      if (s[3:0] != 4'd0) return {m, s[7:4], s[3:0] - 4'd1};
      if (s[7:4] != 4'd0) return {m, s[7:4] - 4'd1, 4'd9};
      if (m[3:0] != 4'd0) return {m[7:4], m[3:0] - 4'd1, 8'h59};
      return {m[7:4] - 4'd1, 4'd9, 8'h59};
   endfunction

   assign load_valid = (bus.load_min[7:4] <= 4'd9) && (bus.load_min[3:0] <= 4'd9) &&
                       (bus.load_sec[7:4] <= 4'd5) && (bus.load_sec[3:0] <= 4'd9);
   assign count_nz   = ({min_q, sec_q} != 16'h0000);
   assign dec        = bcd_dec(min_q, sec_q);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [15:0] shadow_q;
   logic        shadow_we;

   assign shadow_we = !bus.clear && bus.load && (state_q != StRun) && load_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= 16'h0000;
      end else if (shadow_we) begin
         shadow_q <= {bus.load_min, bus.load_sec};
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      min_d      = min_q;
      sec_d      = sec_q;
      presc_d    = presc_q;
      done_d     = 1'b0;
      load_err_d = 1'b0;
      if (bus.clear) begin
         state_d = StIdle;
         min_d   = 8'h00;
         sec_d   = 8'h00;
         presc_d = '0;
      end else if (bus.load && (state_q != StRun)) begin
         if (load_valid) begin
            min_d   = bus.load_min;
            sec_d   = bus.load_sec;
            presc_d = '0;
            if (state_q == StAlarm) state_d = StIdle;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (bus.stop && (state_q == StRun)) begin
         // Pending tick is dropped; prescaler keeps its partial count for resume.
         state_d = StPause;
      end else if (bus.start && ((state_q == StIdle) || (state_q == StPause))) begin
         if (count_nz) state_d = StRun;
      end else if (bus.tick && (state_q == StRun)) begin
         if (presc_q == PrescLast) begin
            presc_d = '0;
            if (dec == 16'h0000) begin
               done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               if (shadow_q != 16'h0000) begin
                  {min_d, sec_d} = shadow_q;
               end else begin
                  {min_d, sec_d} = 16'h0000;
                  state_d        = StAlarm;
               end
`else
               {min_d, sec_d} = 16'h0000;
               state_d        = StAlarm;
`endif
            end else begin
               {min_d, sec_d} = dec;
            end
         end else begin
            presc_d = presc_q + PRESC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         min_q      <= 8'h00;
         sec_q      <= 8'h00;
         presc_q    <= '0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         presc_q    <= presc_d;
         done_q     <= done_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.min_out  = min_q;
   assign bus.sec_out  = sec_q;
   assign bus.running  = (state_q == StRun);
   assign bus.alarm    = (state_q == StAlarm);
   assign bus.done     = done_q;
   assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_countdown_bcd.sv
// Scoreboard bench for countdown_bcd at TICK_DIV=2: each step pushes the expected outputs,
// drives one clock, then pops and compares {min, sec, running, alarm, done, load_err}.
module tb_countdown_bcd;
   logic clk = 1'b0;
   logic reset = 1'b1;

   countdown_bcd_if bus ();

   countdown_bcd #(
      .TICK_DIV (2),
      .PRESC_W  (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rs;
      logic        t;
      logic        ld;
      logic [7:0]  lm;
      logic [7:0]  ls;
      logic        st;
      logic        sp;
      logic        cl;
      logic [19:0] e;
   } vec_t;

   logic [19:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;

   function automatic logic [19:0] ex(input logic [7:0] m, input logic [7:0] s, input logic r,
                                      input logic a, input logic d, input logic le);
      return {m, s, r, a, d, le};
   endfunction

   function automatic vec_t v(input logic rs, input logic t, input logic ld, input logic [7:0] lm,
                              input logic [7:0] ls, input logic st, input logic sp, input logic cl,
                              input logic [19:0] e);
      return '{rs: rs, t: t, ld: ld, lm: lm, ls: ls, st: st, sp: sp, cl: cl, e: e};
   endfunction

   function automatic logic [19:0] obs();
      return {bus.min_out, bus.sec_out, bus.running, bus.alarm, bus.done, bus.load_err};
   endfunction

   // Inputs are applied between edges and released 1 time unit after the edge.
   task automatic step(input vec_t s);
      reset        = s.rs;
      bus.tick     = s.t;
      bus.load     = s.ld;
      bus.load_min = s.lm;
      bus.load_sec = s.ls;
      bus.start    = s.st;
      bus.stop     = s.sp;
      bus.clear    = s.cl;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      bus.tick  = 1'b0;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.clear = 1'b0;
   endtask

   task automatic test_reset();
      vec_t        q[$];
      logic [19:0] got, want;
      q.push_back(v(1, 1, 1, 8'h12, 8'h34, 1, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      foreach (q[i]) begin
         exp_q.push_back(q[i].e);
         step(q[i]);
         got  = obs();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_countdown();
      vec_t        q[$];
      logic [19:0] got, want;
      logic [7:0]  secs[6] = '{8'h03, 8'h02, 8'h02, 8'h01, 8'h01, 8'h00};
      q.push_back(v(0, 0, 1, 8'h00, 8'h03, 0, 0, 0, ex(8'h00, 8'h03, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h03, 1, 0, 0, 0)));
      for (int k = 0; k < 5; k++)
         q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, secs[k], 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 1, 1, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 1, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 1, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h00, 0, 1, 0, 0)));
      q.push_back(v(0, 0, 1, 8'h00, 8'h05, 0, 0, 0, ex(8'h00, 8'h05, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      foreach (q[i]) begin
         exp_q.push_back(q[i].e);
         step(q[i]);
         got  = obs();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL countdown[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_borrow_pause();
      vec_t        q[$];
      logic [19:0] got, want;
      q.push_back(v(0, 0, 1, 8'h01, 8'h00, 0, 0, 0, ex(8'h01, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h01, 8'h00, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h01, 8'h00, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h59, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 1, 0, ex(8'h00, 8'h59, 0, 0, 0, 0)));
      for (int k = 0; k < 9; k++)
         q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h59, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h59, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h59, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h58, 1, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 1, 8'h10, 8'h00, 0, 0, 0, ex(8'h10, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h10, 8'h00, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h10, 8'h00, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h09, 8'h59, 1, 0, 0, 0)));
      foreach (q[i]) begin
         exp_q.push_back(q[i].e);
         step(q[i]);
         got  = obs();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL borrow_pause[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_load_err();
      vec_t        q[$];
      logic [19:0] got, want;
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, ex(8'h09, 8'h59, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 1, 8'h00, 8'h60, 0, 0, 0, ex(8'h09, 8'h59, 0, 0, 0, 1)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h09, 8'h59, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 1, 8'h1A, 8'h00, 0, 0, 0, ex(8'h09, 8'h59, 0, 0, 0, 1)));
      q.push_back(v(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      foreach (q[i]) begin
         exp_q.push_back(q[i].e);
         step(q[i]);
         got  = obs();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL load_err[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_same_cycle();
      vec_t        q[$];
      logic [19:0] got, want;
      q.push_back(v(0, 0, 1, 8'h00, 8'h10, 0, 0, 0, ex(8'h00, 8'h10, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h10, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 1, 8'h00, 8'h30, 0, 0, 0, ex(8'h00, 8'h10, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 1, 0, ex(8'h00, 8'h10, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h10, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h09, 1, 0, 0, 0)));
      q.push_back(v(0, 0, 1, 8'h00, 8'h7A, 0, 0, 0, ex(8'h00, 8'h09, 1, 0, 0, 0)));
      q.push_back(v(0, 0, 1, 8'h00, 8'h20, 1, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      foreach (q[i]) begin
         exp_q.push_back(q[i].e);
         step(q[i]);
         got  = obs();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL same_cycle[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      vec_t        q[$];
      logic [19:0] got, want;
      q.push_back(v(0, 0, 1, 8'h00, 8'h45, 0, 0, 0, ex(8'h00, 8'h45, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h45, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h45, 1, 0, 0, 0)));
      q.push_back(v(1, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 1, 8'h00, 8'h02, 0, 0, 0, ex(8'h00, 8'h02, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h02, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h02, 1, 0, 0, 0)));
      q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ex(8'h00, 8'h01, 1, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      foreach (q[i]) begin
         exp_q.push_back(q[i].e);
         step(q[i]);
         got  = obs();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset_mid_run[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      vec_t        q[$];
      logic [19:0] got, want;
      logic [7:0]  secs[8] = '{8'h02, 8'h01, 8'h01, 8'h02, 8'h02, 8'h01, 8'h01, 8'h02};
      q.push_back(v(0, 0, 1, 8'h00, 8'h02, 0, 0, 0, ex(8'h00, 8'h02, 0, 0, 0, 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, ex(8'h00, 8'h02, 1, 0, 0, 0)));
      for (int k = 0; k < 8; k++)
         q.push_back(v(0, 1, 0, 8'h00, 8'h00, 0, 0, 0,
                       ex(8'h00, secs[k], 1, 0, (k == 3) || (k == 7), 0)));
      q.push_back(v(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0)));
      foreach (q[i]) begin
         exp_q.push_back(q[i].e);
         step(q[i]);
         got  = obs();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL auto_reload[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask
`endif

   initial begin
      bus.tick     = 1'b0;
      bus.load     = 1'b0;
      bus.load_min = 8'h00;
      bus.load_sec = 8'h00;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.clear    = 1'b0;
      @(negedge clk);
      test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      test_auto_reload();
`else
      test_countdown();
`endif
      test_borrow_pause();
      test_load_err();
      test_same_cycle();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
